// File: rtl/pwr_cntr_reader_pkg.sv
// pwr_cntr_reader_pkg
//   Shared definitions for the power-counter read-out controller.
//   - Address width and counter count (`Ndir, `NumPwrCntr) and the FSM state
//     encodings (`PWR_RD_*). These mirror definitions.v and are guarded so an
//     already-included definitions.v takes precedence.
//   - sat_add(): 32-bit add that clamps to all-ones on carry out.
`ifndef Ndir
`define Ndir 2
`endif
`ifndef NumPwrCntr
`define NumPwrCntr 7
`endif
`ifndef PWR_RD_IDLE
`define PWR_RD_IDLE    3'd0
`define PWR_RD_SETUP   3'd1
`define PWR_RD_CAPTURE 3'd2
`define PWR_RD_PRESENT 3'd3
`define PWR_RD_CLEAR   3'd4
`define PWR_RD_RESTORE 3'd5
`define PWR_RD_NEXT    3'd6
`endif

package pwr_cntr_reader_pkg;

  localparam int NDIR         = `Ndir;
  localparam int DIR_W        = NDIR + 1;
  localparam int NUM_PWR_CNTR = `NumPwrCntr;

  typedef enum logic [2:0] {
    ST_IDLE    = `PWR_RD_IDLE,
    ST_SETUP   = `PWR_RD_SETUP,
    ST_CAPTURE = `PWR_RD_CAPTURE,
    ST_PRESENT = `PWR_RD_PRESENT,
    ST_CLEAR   = `PWR_RD_CLEAR,
    ST_RESTORE = `PWR_RD_RESTORE,
    ST_NEXT    = `PWR_RD_NEXT
  } rd_state_e;

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
  } sat_res_t;

  // 33-bit add; a carry out clamps the result to all-ones and flags overflow.
  function automatic sat_res_t sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    sat_res_t    r;
    s = {1'b0, a} + {1'b0, b};
    if (s[32]) begin
      r.sum = 32'hFFFF_FFFF;
      r.ovf = 1'b1;
    end else begin
      r.sum = s[31:0];
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwr_sat_acc.sv
// pwr_sat_acc
//   32-bit saturating accumulator. Once it saturates it holds all-ones and the
//   sticky overflow flag until cleared.
//   Ports: CLK, RESET (sync, active-high), clr_i (zero sum and flag),
//          en_i (add data_i), data_i[31:0], sum_o[31:0], ovf_o.
module pwr_sat_acc
  import pwr_cntr_reader_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] sum_o,
  output logic        ovf_o
);

  logic [31:0] sum_q, sum_d;
  logic        ovf_q, ovf_d;
  sat_res_t    sat_s;

  // Next-state: clear has priority; a saturated sum is frozen until cleared.
  always_comb begin
    sat_s = sat_add(sum_q, data_i);
    if (clr_i) begin
      sum_d = 32'h0000_0000;
      ovf_d = 1'b0;
    end else if (en_i && !ovf_q) begin
      sum_d = sat_s.sum;
      ovf_d = sat_s.ovf;
    end else begin
      sum_d = sum_q;
      ovf_d = ovf_q;
    end
  end

  // Accumulator state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sum_q <= 32'h0000_0000;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum_o = sum_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pwr_cntr_reader.sv
// pwr_cntr_reader
//   Bus master for the power-counter memory. On START it walks addresses
//   0..NumPwrCntr, samples each 32-bit count, presents it on a valid/ready
//   stream, keeps a saturating total and optionally zeroes each counter after
//   delivery.
//   Ports: CLK, RESET (sync, active-high), START, CLR_EN, OUT_READY;
//          OUT_VALID, OUT_DIR, OUT_DATA, SUM, SUM_OVF, BUSY, DONE (stream/status);
//          dir, LE, dato (memory bus; LE=1 read, LE=0 write of zero).
module pwr_cntr_reader
  import pwr_cntr_reader_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             CLR_EN,
  input  logic             OUT_READY,
  output logic             OUT_VALID,
  output logic [DIR_W-1:0] OUT_DIR,
  output logic [31:0]      OUT_DATA,
  output logic [31:0]      SUM,
  output logic             SUM_OVF,
  output logic             BUSY,
  output logic             DONE,
  output logic [DIR_W-1:0] dir,
  output logic             LE,
  inout  wire  [31:0]      dato
);

  localparam int               CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_L = CNT_W'(SETTLE_CYC - 1);
  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_PWR_CNTR);

  rd_state_e        state_q;
  logic [CNT_W-1:0] settle_q;
  logic             clr_en_q;
  logic             drv_en_q;   // always the complement of le_q
  logic             le_q;
  logic [DIR_W-1:0] dir_q;
  logic             out_valid_q;
  logic [DIR_W-1:0] out_dir_q;
  logic [31:0]      out_data_q;
  logic             busy_q;
  logic             done_q;
  logic             acc_clr_s;
  logic             acc_en_s;

  // The only driver of dato from this side: zero while writing, else released.
  assign dato = drv_en_q ? 32'h0000_0000 : 32'bz;

  assign acc_clr_s = (state_q == ST_IDLE) && START;
  assign acc_en_s  = (state_q == ST_CAPTURE);

  pwr_sat_acc u_acc (
    .CLK    (CLK),
    .RESET  (RESET),
    .clr_i  (acc_clr_s),
    .en_i   (acc_en_s),
    .data_i (dato),
    .sum_o  (SUM),
    .ovf_o  (SUM_OVF)
  );

  // Scan FSM with registered bus and stream outputs. dir only moves in
  // IDLE/NEXT, where LE is 1, so no address change ever happens mid-write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      clr_en_q    <= 1'b0;
      drv_en_q    <= 1'b0;
      le_q        <= 1'b1;
      dir_q       <= '0;
      out_valid_q <= 1'b0;
      out_dir_q   <= '0;
      out_data_q  <= 32'h0000_0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          le_q     <= 1'b1;
          drv_en_q <= 1'b0;
          dir_q    <= '0;
          if (START) begin
            clr_en_q <= CLR_EN;
            busy_q   <= 1'b1;
            settle_q <= '0;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (settle_q == SETTLE_L) begin
            state_q <= ST_CAPTURE;
          end else begin
            settle_q <= settle_q + CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          out_data_q  <= dato;
          out_dir_q   <= dir_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            if (clr_en_q) begin
              le_q     <= 1'b0;
              drv_en_q <= 1'b1;
              state_q  <= ST_CLEAR;
            end else begin
              state_q <= ST_NEXT;
            end
          end
        end
        ST_CLEAR: begin
          le_q     <= 1'b1;
          drv_en_q <= 1'b0;
          state_q  <= ST_RESTORE;
        end
        ST_RESTORE: begin
          state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          settle_q <= '0;
          if (dir_q == LAST_DIR) begin
            dir_q   <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            dir_q   <= dir_q + DIR_W'(1);
            state_q <= ST_SETUP;
          end
        end
        default: begin
          le_q        <= 1'b1;
          drv_en_q    <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DIR   = out_dir_q;
  assign OUT_DATA  = out_data_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign dir       = dir_q;
  assign LE        = le_q;

endmodule

// File: tb/tb_pwr_cntr_reader.sv
// tb_pwr_cntr_reader
//   Directed bench: a behavioural power-counter memory on dir/LE/dato, a
//   stream monitor, and hand-computed expectations per scan.
module tb_pwr_cntr_reader;
  import pwr_cntr_reader_pkg::*;

  localparam int N = NUM_PWR_CNTR + 1;

  logic             CLK = 1'b0;
  logic             RESET, START, CLR_EN, OUT_READY;
  logic             OUT_VALID, SUM_OVF, BUSY, DONE, LE;
  logic [DIR_W-1:0] OUT_DIR, dir;
  logic [31:0]      OUT_DATA, SUM;
  wire  [31:0]      dato;

  logic [31:0] mem [0:N-1];
  logic [31:0] img [0:N-1];
  logic        load_req = 1'b0;
  int          wr_count = 0;

  logic [DIR_W-1:0] bd_q [$];
  logic [31:0]      bv_q [$];
  int               stall_cycles = 0, stall_bad = 0, dir_viol = 0, ovf_drop = 0;
  logic             stall_prev = 1'b0, le_lo_prev = 1'b0, ovf_seen = 1'b0, ovf_watch = 1'b0;
  logic [31:0]      held_data = 32'h0;
  logic [DIR_W-1:0] held_dir = '0, lo_dir = '0;

  int n_pass = 0, n_checks = 0;

  pwr_cntr_reader #(.SETTLE_CYC(1)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .CLR_EN(CLR_EN), .OUT_READY(OUT_READY),
    .OUT_VALID(OUT_VALID), .OUT_DIR(OUT_DIR), .OUT_DATA(OUT_DATA), .SUM(SUM),
    .SUM_OVF(SUM_OVF), .BUSY(BUSY), .DONE(DONE), .dir(dir), .LE(LE), .dato(dato)
  );

  always #5 CLK = ~CLK;

  // Memory: drives the addressed counter while LE=1, writes dato while LE=0.
  assign dato = LE ? mem[dir] : 32'bz;

  always @(posedge CLK) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) mem[i] <= img[i];
    end else if (!LE) begin
      mem[dir] <= dato;
      wr_count <= wr_count + 1;
    end
  end

  // Stream, stall-stability, write-address and overflow-stickiness monitor.
  always @(negedge CLK) begin
    if (OUT_VALID && OUT_READY) begin
      bd_q.push_back(OUT_DIR);
      bv_q.push_back(OUT_DATA);
    end
    if (OUT_VALID && !OUT_READY) begin
      stall_cycles <= stall_cycles + 1;
      if (stall_prev && (OUT_DATA != held_data || OUT_DIR != held_dir || dir != held_dir))
        stall_bad <= stall_bad + 1;
    end
    stall_prev <= OUT_VALID && !OUT_READY;
    held_data  <= OUT_DATA;
    held_dir   <= OUT_DIR;
    if (!LE && le_lo_prev && dir != lo_dir) dir_viol <= dir_viol + 1;
    le_lo_prev <= !LE;
    lo_dir     <= dir;
    if (ovf_watch && ovf_seen && !SUM_OVF) ovf_drop <= ovf_drop + 1;
    ovf_seen <= ovf_watch && (ovf_seen || SUM_OVF);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic preload(input logic [31:0] v0, input logic [31:0] v1);
    for (int i = 0; i < N; i++) img[i] = 32'(i + 5);
    img[0] = v0;
    img[1] = v1;
    load_req = 1'b1;
    @(posedge CLK); #1;
    load_req = 1'b0;
  endtask

  // One scan from START to DONE; stall_entry<0 disables the 10-cycle stall.
  task automatic run_scan(input bit clr, input int stall_entry, input bit dbl,
                          input logic [31:0] exp_sum, input bit exp_ovf, input int exp_cycles);
    int base, cycles, stall_left, st0, wr0;
    base = bd_q.size();
    st0  = stall_cycles;
    wr0  = wr_count;
    stall_left = (stall_entry >= 0) ? 10 : 0;
    START = 1'b1;
    CLR_EN = clr;
    @(posedge CLK); #1;
    START = 1'b0;
    CLR_EN = ~clr;
    check("sum_zero_on_start", SUM, 0);
    check("ovf_zero_on_start", SUM_OVF, 0);
    check("busy_after_start", BUSY, 1);
    cycles = 0;
    while (cycles < 2000) begin
      if (OUT_VALID && int'(OUT_DIR) == stall_entry && stall_left > 0) begin
        OUT_READY = 1'b0;
        stall_left--;
      end else begin
        OUT_READY = 1'b1;
      end
      START = (dbl && cycles == 5) ? 1'b1 : 1'b0;
      @(posedge CLK);
      cycles++;
      #1;
      if (DONE) break;
    end
    START = 1'b0;
    if (!DONE) check("done_timeout", 0, 1);
    check("scan_cycles", cycles, exp_cycles);
    check("busy_drop_with_done", BUSY, 0);
    check("beat_count", bd_q.size() - base, N);
    for (int i = 0; i < N && base + i < bd_q.size(); i++) begin
      check("beat_dir", bd_q[base+i], i);
      check("beat_data", bv_q[base+i], img[i]);
    end
    check("sum", SUM, exp_sum);
    check("sum_ovf", SUM_OVF, exp_ovf);
    check("stall_cycles", stall_cycles - st0, (stall_entry >= 0) ? 10 : 0);
    check("write_count", wr_count - wr0, clr ? N : 0);
    for (int i = 0; i < N; i++) check("mem_after_scan", mem[i], clr ? 32'h0 : img[i]);
    @(posedge CLK); #1;
    check("done_one_cycle", DONE, 0);
    check("sum_held", SUM, exp_sum);
  endtask

  initial begin
    int guard, wr0;
    RESET = 1'b1; START = 1'b1; CLR_EN = 1'b0; OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_dir", OUT_DIR, 0);
    check("rst_out_data", OUT_DATA, 0);
    check("rst_sum", SUM, 0);
    check("rst_sum_ovf", SUM_OVF, 0);
    check("rst_busy_start_ignored", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_dir", dir, 0);
    check("rst_le", LE, 1);
    START = 1'b0; RESET = 1'b0;
    @(posedge CLK); #1;
    check("idle_busy", BUSY, 0);

    // Plain scan, then clearing scan on the same preload.
    preload(32'd5, 32'd6);
    run_scan(1'b0, -1, 1'b0, 32'd68, 1'b0, N * 4);
    run_scan(1'b1, -1, 1'b0, 32'd68, 1'b0, N * 6);
    check("dir_stable_while_writing", dir_viol, 0);

    // Ten-cycle stall on entry 2 (value 7).
    preload(32'd5, 32'd6);
    run_scan(1'b0, 2, 1'b0, 32'd68, 1'b0, N * 4 + 10);
    check("stall_stable", stall_bad, 0);

    // Saturation on entries 0 and 1; sticky until the next START.
    preload(32'hFFFF_FFF0, 32'hFFFF_FFF0);
    ovf_watch = 1'b1;
    run_scan(1'b0, -1, 1'b0, 32'hFFFF_FFFF, 1'b1, N * 4);
    ovf_watch = 1'b0;
    check("ovf_sticky", ovf_drop, 0);
    preload(32'd5, 32'd6);
    run_scan(1'b0, -1, 1'b0, 32'd68, 1'b0, N * 4);

    // Repeated START while busy is ignored.
    run_scan(1'b0, -1, 1'b1, 32'd68, 1'b0, N * 4);

    // RESET during CLEAR of entry 3.
    wr0 = wr_count;
    START = 1'b1; CLR_EN = 1'b1; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    guard = 0;
    while (!(!LE && dir == 3'd3) && guard < 200) begin
      @(posedge CLK); #1;
      guard++;
    end
    check("reach_clear3", guard < 200, 1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("rstmid_le", LE, 1);
    check("rstmid_busy", BUSY, 0);
    check("rstmid_dir", dir, 0);
    check("rstmid_valid", OUT_VALID, 0);
    check("rstmid_mem3_cleared", mem[3], 0);
    check("rstmid_mem4_kept", mem[4], 9);
    check("rstmid_writes", wr_count - wr0, 4);
    preload(32'd5, 32'd6);
    run_scan(1'b0, -1, 1'b0, 32'd68, 1'b0, N * 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
